// File: rtl/sigmoid_pwl_pipe_if.sv
// Stream interface of the piecewise-linear activation unit: input and output
// valid/ready channels plus the saturation counter readout.
interface sigmoid_pwl_pipe_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  sat_count;

    // Producer/consumer side (testbench or surrounding datapath)
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, sat_count
    );

    // Activation unit side
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, sat_count
    );
endinterface

// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage pipelined piecewise-linear sigmoid/tanh unit.
// Stage 1 folds the sample to a magnitude and picks a segment, stage 2 applies
// the gradient/offset of that segment, stage 3 undoes the symmetry fold and maps
// to the tanh range when requested. A single enable advances all stages.
module sigmoid_pwl_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    sigmoid_pwl_pipe_if.slave bus
);
    localparam int M_W    = DATA_W + 1;      // magnitude keeps 2^(DATA_W-1) exact
    localparam int K_W    = M_W - FRAC_W;    // integer part of the magnitude
    localparam int PROD_W = M_W + 8;         // magnitude times a Q0.8 gradient
    localparam int Q_W    = DATA_W + 2;      // headroom for ONE - p and 2q
    localparam logic [Q_W-1:0] ONE = Q_W'(64'd1 << FRAC_W);

    // Segment gradients in Q0.8
    function automatic logic [7:0] grad(input logic [2:0] s);
        case (s)
            3'd0:    return 8'h3B;
            3'd1:    return 8'h26;
            3'd2:    return 8'h12;
            3'd3:    return 8'h08;
            3'd4:    return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    // Segment offsets in Q0.8
    function automatic logic [7:0] offs(input logic [2:0] s);
        case (s)
            3'd0:    return 8'h80;
            3'd1:    return 8'h90;
            3'd2:    return 8'hBD;
            3'd3:    return 8'hDD;
            3'd4:    return 8'hF0;
            default: return 8'hF9;
        endcase
    endfunction

    logic                  w_en;
    logic                  w_ovf;
    logic [DATA_W-1:0]     w_xp;
    logic [M_W-1:0]        w_xp_ext;
    logic [M_W-1:0]        w_mag;
    logic [K_W-1:0]        w_k;
    logic                  w_sat1;
    logic [PROD_W-1:0]     w_prod;
    logic [Q_W-1:0]        w_p;
    logic signed [Q_W-1:0] w_q;
    logic signed [Q_W-1:0] w_qc;
    logic signed [Q_W-1:0] w_y;

    logic                  r1_valid, r1_sgn, r1_sat, r1_mode;
    logic [2:0]            r1_seg;
    logic [M_W-1:0]        r1_mag;
    logic                  r2_valid, r2_sgn, r2_sat, r2_mode;
    logic [Q_W-1:0]        r2_p;
    logic                  r_out_valid, r_out_sat;
    logic [DATA_W-1:0]     r_out_data;
    logic [CNT_W-1:0]      r_sat_count;

    // The whole pipe moves whenever the output register is free or being drained
    assign w_en          = bus.out_ready | ~r_out_valid;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.sat_count = r_sat_count;

    // Stage 1 logic: optional doubling with saturation, sign/magnitude split, segment pick
    // NOTE: every signal is assigned on every path through this block, so no latch is inferred.
    always_comb begin
        w_ovf = bus.in_data[DATA_W-1] ^ bus.in_data[DATA_W-2];
        if (!bus.in_mode)
            w_xp = bus.in_data;
        else if (w_ovf)
            w_xp = {bus.in_data[DATA_W-1], {(DATA_W-1){~bus.in_data[DATA_W-1]}}};
        else
            w_xp = {bus.in_data[DATA_W-2:0], 1'b0};
        w_xp_ext = {w_xp[DATA_W-1], w_xp};
        w_mag    = w_xp[DATA_W-1] ? (~w_xp_ext + M_W'(1)) : w_xp_ext;
        w_k      = w_mag[M_W-1:FRAC_W];
        w_sat1   = (w_k > K_W'(5));
    end

    // Stage 2 logic: gradient times magnitude plus offset, or ONE when saturated
    always_comb begin
        w_prod = PROD_W'(r1_mag) * PROD_W'(grad(r1_seg));
        if (r1_sat)
            w_p = ONE;
        else
            w_p = Q_W'(w_prod >> 8) + (Q_W'(offs(r1_seg)) << (FRAC_W - 8));
    end

    // Stage 3 logic: mirror negative inputs, clamp to [0, ONE], remap for tanh
    always_comb begin
        w_q = r2_sgn ? $signed(ONE - r2_p) : $signed(r2_p);
        if (w_q[Q_W-1])
            w_qc = '0;
        else if (w_q > $signed(ONE))
            w_qc = $signed(ONE);
        else
            w_qc = w_q;
        w_y = r2_mode ? ((w_qc <<< 1) - $signed(ONE)) : w_qc;
    end

    // Valid chain and output register; reset discards everything in flight
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r2_valid    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_en) begin
            r1_valid    <= bus.in_valid;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
            r_out_data  <= w_y[DATA_W-1:0];
            r_out_sat   <= r2_valid & r2_sat;
        end
    end

    // Intermediate datapath registers; their contents are qualified by the valid chain
    // NOTE: no reset here on purpose -- a stale value is never observed because its valid bit is cleared.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r1_sgn  <= w_xp[DATA_W-1];
            r1_seg  <= w_k[2:0];
            r1_mag  <= w_mag;
            r1_sat  <= w_sat1;
            r1_mode <= bus.in_mode;
            r2_p    <= w_p;
            r2_sgn  <= r1_sgn;
            r2_sat  <= r1_sat;
            r2_mode <= r1_mode;
        end
    end

    // Count saturated samples as they leave, sticking at the maximum
    always_ff @(posedge clk) begin
        if (rst)
            r_sat_count <= '0;
        else if (r_out_valid && bus.out_ready && r_out_sat && (r_sat_count != '1))
            r_sat_count <= r_sat_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Scoreboard bench for sigmoid_pwl_pipe: a driver pushes expected results on
// accept, a monitor pops and compares whenever an output is handed over.
module tb_sigmoid_pwl_pipe;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [15:0] y;
        bit          sat;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_sat = 0;
    int   ready_mode = 0;
    int   phase_start = 0;
    bit   chk_lat_mode = 1'b0;
    exp_t sb[$];

    sigmoid_pwl_pipe_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sigmoid_pwl_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer evaluation of the segment table with saturation and symmetry
    function automatic exp_t model(input logic [15:0] x, input bit m);
        int g[6] = '{59, 38, 18, 8, 3, 1};
        int b[6] = '{128, 144, 189, 221, 240, 249};
        int xs, xp, a, k, p, q, y;
        exp_t e;
        xs = int'($signed(x));
        xp = m ? 2 * xs : xs;
        if (xp > 32767)  xp = 32767;
        if (xp < -32768) xp = -32768;
        a = (xp < 0) ? -xp : xp;
        k = a / 256;
        e.sat = (k >= 6);
        if (e.sat) p = 256;
        else       p = (g[k] * a) / 256 + b[k];
        q = (xp < 0) ? 256 - p : p;
        if (q < 0)   q = 0;
        if (q > 256) q = 256;
        y = m ? 2 * q - 256 : q;
        e.y = 16'(y);
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    function automatic logic [15:0] rand_x();
        if ($urandom_range(1) == 0) return 16'($urandom);
        return 16'(int'($urandom_range(0, 3584)) - 1792);
    endfunction

    // Present one sample, wait (bounded) for acceptance, and record its expectation
    task automatic send(input logic [15:0] x, input bit m, input bit use_exp,
                        input logic [15:0] ey, input bit es);
        exp_t e;
        int n = 0;
        e = model(x, m);
        if (use_exp) begin
            e.y   = ey;
            e.sat = es;
        end
        e.chk_lat    = chk_lat_mode;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        bus.in_mode  = m;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check(1'b0, "accept_timeout", n, 200);
        end else begin
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check(1'b0, "drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Downstream ready pattern
    initial begin
        int r;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            r = cyc - phase_start;
            case (ready_mode)
                1:       bus.out_ready = ($urandom_range(3) != 0);
                2:       bus.out_ready = !(r >= 6 && r <= 10);
                3:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares every handed-over output against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                exp_sat = 0;
            end else begin
                check(bus.in_ready === (bus.out_ready | ~bus.out_valid), "in_ready",
                      int'(bus.in_ready), int'(bus.out_ready | ~bus.out_valid));
                check(int'(bus.sat_count) == exp_sat, "sat_count", int'(bus.sat_count), exp_sat);
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_output", int'(bus.out_data), 0);
                    end else begin
                        e = sb.pop_front();
                        check(bus.out_data === e.y, "out_data", int'(bus.out_data), int'(e.y));
                        if (e.chk_lat) check(cyc - e.acc_cyc == 3, "latency", cyc - e.acc_cyc, 3);
                        if (e.sat && exp_sat < 65535) exp_sat++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Stimulus sequence
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_mode  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(bus.out_valid === 1'b0, "rst_out_valid", int'(bus.out_valid), 0);
        check(bus.out_data === 16'h0, "rst_out_data", int'(bus.out_data), 0);
        check(bus.sat_count === 16'h0, "rst_sat_count", int'(bus.sat_count), 0);
        check(bus.in_ready === 1'b1, "rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Sigmoid points with latency check
        chk_lat_mode = 1'b1;
        send(16'h0000, 1'b0, 1'b1, 16'h0080, 1'b0);
        send(16'h0100, 1'b0, 1'b1, 16'h00B6, 1'b0);
        send(16'hFF00, 1'b0, 1'b1, 16'h004A, 1'b0);
        drain();
        chk_lat_mode = 1'b0;

        // Saturation
        send(16'h0600, 1'b0, 1'b1, 16'h0100, 1'b1);
        send(16'h0800, 1'b0, 1'b1, 16'h0100, 1'b1);
        send(16'h7FFF, 1'b0, 1'b1, 16'h0100, 1'b1);
        send(16'hF800, 1'b0, 1'b1, 16'h0000, 1'b1);
        send(16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1);
        drain();
        @(negedge clk);
        check(bus.sat_count === 16'd5, "sat_count_5", int'(bus.sat_count), 5);
        @(posedge clk);
        #1;

        // Tanh points, including the most-negative input
        send(16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
        send(16'h0080, 1'b1, 1'b1, 16'h006C, 1'b0);
        send(16'hFF80, 1'b1, 1'b1, 16'hFF94, 1'b0);
        send(16'h4000, 1'b1, 1'b1, 16'h0100, 1'b1);
        send(16'h8000, 1'b1, 1'b1, 16'hFF00, 1'b1);
        drain();

        // 20-sample stream with a downstream stall
        phase_start = cyc;
        ready_mode  = 2;
        for (int i = 0; i < 20; i++) send(rand_x(), 1'($urandom_range(1)), 1'b0, 16'h0, 1'b0);
        drain();
        ready_mode = 0;

        // Alternating modes, back to back, random ready
        ready_mode = 1;
        for (int i = 0; i < 40; i++) send(rand_x(), 1'(i % 2), 1'b0, 16'h0, 1'b0);
        drain();

        // Random traffic with idle gaps
        for (int i = 0; i < 300; i++) begin
            send(rand_x(), 1'($urandom_range(1)), 1'b0, 16'h0, 1'b0);
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        drain();

        // Reset with three samples in flight and the output stalled
        ready_mode = 3;
        send(16'h0600, 1'b0, 1'b0, 16'h0, 1'b0);
        send(rand_x(), 1'b1, 1'b0, 16'h0, 1'b0);
        send(rand_x(), 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        check(bus.out_valid === 1'b1, "stall_out_valid", int'(bus.out_valid), 1);
        check(bus.in_ready === 1'b0, "stall_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check(bus.out_valid === 1'b0, "mid_rst_out_valid", int'(bus.out_valid), 0);
        check(bus.sat_count === 16'h0, "mid_rst_sat_count", int'(bus.sat_count), 0);
        ready_mode = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check(bus.out_valid === 1'b0, "no_stale_output", int'(bus.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
